// File: rtl/ct_mod_range.sv
// Range counter [MIN..top] with up/down wrap, clamped load, optional runtime
// upper bound, combinational carry chaining and a registered compare-match pulse.
module ct_mod_range #(
    parameter int unsigned W       = 7,
    parameter int unsigned MIN     = 0,
    parameter int unsigned MAX     = 59,
    parameter int unsigned DYN     = 0,
    parameter int unsigned RST_VAL = MIN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         dn,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] max_dyn,
    input  logic         cmp_en,
    input  logic [W-1:0] cmp_val,
    output logic [W-1:0] ct_out,
    output logic         tc,
    output logic         co,
    output logic         match
);

    localparam logic [W-1:0] MinW = W'(MIN);
    localparam logic [W-1:0] MaxW = W'(MAX);
    localparam logic [W-1:0] RstW = W'(RST_VAL);

    // Elaboration-time parameter sanity.
    if (MIN >= MAX) begin : g_err_min_max
        $error("ct_mod_range: MIN must be below MAX");
    end
    if (longint'(MAX) > ((longint'(1) << W) - 1)) begin : g_err_max_width
        $error("ct_mod_range: MAX does not fit in W bits");
    end
    if ((RST_VAL < MIN) || (RST_VAL > MAX)) begin : g_err_rst_val
        $error("ct_mod_range: RST_VAL outside [MIN..MAX]");
    end

    // Comparisons against MIN written without >=/< so MIN=0 stays free of
    // constant-result unsigned compares.
    function automatic logic le_min(input logic [W-1:0] x);
        return !(x > MinW);
    endfunction

    function automatic logic lt_min(input logic [W-1:0] x);
        return !(x > MinW) && (x != MinW);
    endfunction

    logic [W-1:0] top;
    logic [W-1:0] cnt_q, cnt_d;
    logic         match_q, match_d;

    if (DYN != 0) begin : g_dyn
        assign top = lt_min(max_dyn) ? MinW : max_dyn;
    end else begin : g_static
        logic unused_max_dyn;
        assign unused_max_dyn = ^max_dyn;
        assign top = MaxW;
    end

    // Next count (ld over en) and next match flag.
    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            if (lt_min(ld_val)) begin
                cnt_d = MinW;
            end else if (ld_val > top) begin
                cnt_d = top;
            end else begin
                cnt_d = ld_val;
            end
        end else if (en) begin
            if (!dn) begin
                // >= also catches top having dropped below the current count.
                cnt_d = (cnt_q >= top) ? MinW : cnt_q + 1'b1;
            end else if (le_min(cnt_q) || (cnt_q > top)) begin
                cnt_d = top;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        match_d = cmp_en && (cnt_d == cmp_val) && (cnt_d != cnt_q);
    end

    // Count and match registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= RstW;
            match_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    // Terminal count follows direction only; carry is gated by en and ld.
    always_comb begin
        tc = dn ? le_min(cnt_q) : (cnt_q >= top);
        co = en && tc && !ld;
    end

    assign ct_out = cnt_q;
    assign match  = match_q;

endmodule
